// File: rtl/mealy_seq_det_param.sv
// -----------------------------------------------------------------------------
// mealy_seq_det_param
//   Dual-pattern serial sequence detector with Mealy outputs. Consumed bits
//   shift into a (PAT_LEN-1)-bit history register. A candidate word
//   {history, in} is compared against two live patterns. A match is reported
//   in the same cycle as the bit that completes it.
//
//   A fill count tracks how many valid history bits are held. A match is
//   only allowed once the history is full. In non-overlapping mode a match
//   empties the history, so the next detection needs PAT_LEN fresh bits.
//
//   Optional feature: define MEALY_SEQ_DET_CNT_EN to build saturating hit
//   counters. Without it, cnt_a/cnt_b are tied to 0 and clr is ignored.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..16)
//   CODE_W   width of the match code on out
//   CNT_W    width of each hit counter
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   in      in   serial data bit
//   in_vld  in   qualifies in
//   det_en  in   detector enable (0 empties the fill count)
//   overlap in   1 = overlapping detection, 0 = non-overlapping
//   clr     in   synchronous clear of the hit counters
//   pat_a   in   pattern A, MSB received first
//   pat_b   in   pattern B, MSB received first
//   code_a  in   code driven on out when A matches
//   code_b  in   code driven on out when B matches
//   out     out  Mealy match code (A has priority)
//   hit_a   out  pattern A matched this cycle
//   hit_b   out  pattern B matched this cycle
//   cnt_a   out  pattern A hit count
//   cnt_b   out  pattern B hit count
// -----------------------------------------------------------------------------
module mealy_seq_det_param #(
  parameter int PAT_LEN = 4,
  parameter int CODE_W  = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in,
  input  logic               in_vld,
  input  logic               det_en,
  input  logic               overlap,
  input  logic               clr,
  input  logic [PAT_LEN-1:0] pat_a,
  input  logic [PAT_LEN-1:0] pat_b,
  input  logic [CODE_W-1:0]  code_a,
  input  logic [CODE_W-1:0]  code_b,
  output logic [CODE_W-1:0]  out,
  output logic               hit_a,
  output logic               hit_b,
  output logic [CNT_W-1:0]   cnt_a,
  output logic [CNT_W-1:0]   cnt_b
);

  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_LEN-1:0] cand;
  logic               armed;
  logic               match_a, match_b;

  assign cand = {hist_q, in};

  // fill_q is held at 0 during reset, so armed (and every output) is 0 then.
  assign armed   = in_vld & det_en & (fill_q == FILL_MAX);
  assign match_a = armed & (cand == pat_a);
  assign match_b = armed & (cand == pat_b);

  always_comb begin
    out   = '0;
    hit_a = match_a;
    hit_b = match_b;
    if (match_a)      out = code_a;
    else if (match_b) out = code_b;
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (!det_en) begin
      fill_d = '0;
    end else if (in_vld) begin
      hist_d = cand[PAT_LEN-2:0];
      if (!overlap && (match_a || match_b)) fill_d = '0;
      else if (fill_q != FILL_MAX)          fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

`ifdef MEALY_SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  // clr takes precedence over a hit in the same cycle.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (clr) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      if (match_a && !(&cnt_a_q)) cnt_a_d = cnt_a_q + 1'b1;
      if (match_b && !(&cnt_b_q)) cnt_b_d = cnt_b_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`else
  // Counters are compiled out; clr is kept on the port list but has no effect.
  logic unused_clr;
  assign unused_clr = clr;
  assign cnt_a      = '0;
  assign cnt_b      = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_det_param.sv
// -----------------------------------------------------------------------------
// tb_mealy_seq_det_param
//   Directed bench for mealy_seq_det_param with PAT_LEN=4 and CNT_W=2.
//   pat_a=1001, pat_b=1110, code_a=1001, code_b=1110.
// -----------------------------------------------------------------------------
module tb_mealy_seq_det_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in, in_vld, det_en, overlap, clr;
  logic [3:0] pat_a, pat_b, code_a, code_b;
  logic [3:0] out;
  logic       hit_a, hit_b;
  logic [1:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;
  int stepno = 0;
  int ea = 0;
  int eb = 0;

  mealy_seq_det_param #(.PAT_LEN(4), .CODE_W(4), .CNT_W(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .in_vld (in_vld),
    .det_en (det_en),
    .overlap(overlap),
    .clr    (clr),
    .pat_a  (pat_a),
    .pat_b  (pat_b),
    .code_a (code_a),
    .code_b (code_b),
    .out    (out),
    .hit_a  (hit_a),
    .hit_b  (hit_b),
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s step=%0d got=%0h want=%0h", tag, stepno, act, exp);
    end
  endtask

  function automatic logic [7:0] want_cnt(input int n);
`ifdef MEALY_SEQ_DET_CNT_EN
    return 8'(n);
`else
    return 8'(n * 0);
`endif
  endfunction

  // Apply one bit in the low clock phase, check the Mealy outputs and the
  // counters, then update the expected counts for the coming edge.
  task automatic step(input logic b, input logic v, input logic d, input logic c,
                      input logic [3:0] eo, input logic eha, input logic ehb);
    @(negedge clk);
    stepno++;
    in = b; in_vld = v; det_en = d; clr = c;
    #1;
    chk("out",   {4'b0, out},   {4'b0, eo});
    chk("hit_a", {7'b0, hit_a}, {7'b0, eha});
    chk("hit_b", {7'b0, hit_b}, {7'b0, ehb});
    chk("cnt_a", {6'b0, cnt_a}, want_cnt(ea));
    chk("cnt_b", {6'b0, cnt_b}, want_cnt(eb));
    if (c) begin
      ea = 0; eb = 0;
    end else begin
      if (eha && ea < 3) ea++;
      if (ehb && eb < 3) eb++;
    end
  endtask

  // Asynchronous reset pulse between rising edges, inputs primed for a hit.
  task automatic rst_pulse();
    @(negedge clk);
    stepno++;
    in = 1'b1; in_vld = 1'b1; det_en = 1'b1; clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out",   {4'b0, out},   8'h00);
    chk("rst_hit_a", {7'b0, hit_a}, 8'h00);
    chk("rst_hit_b", {7'b0, hit_b}, 8'h00);
    chk("rst_cnt_a", {6'b0, cnt_a}, 8'h00);
    chk("rst_cnt_b", {6'b0, cnt_b}, 8'h00);
    #2;
    rst_n = 1'b1;
    ea = 0; eb = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    in = 1'b0; in_vld = 1'b0; det_en = 1'b1; overlap = 1'b1; clr = 1'b0;
    pat_a = 4'b1001; pat_b = 4'b1110; code_a = 4'b1001; code_b = 4'b1110;
    repeat (2) @(posedge clk);
    #1;
    chk("init_out",   {4'b0, out},   8'h00);
    chk("init_cnt_a", {6'b0, cnt_a}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // 1,0,0,1 -> A on bit 4 only
    step(1,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0);
    step(0,1,1,0, 4'h0,0,0); step(1,1,1,0, 4'h9,1,0);
    // det_en=0 clears fill, no outputs
    step(1,1,0,0, 4'h0,0,0);

    // overlapping 1001001 -> hits on bits 4 and 7
    step(1,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0);
    step(1,1,1,0, 4'h9,1,0); step(0,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0);
    step(1,1,1,0, 4'h9,1,0);
    step(1,1,0,0, 4'h0,0,0);

    // non-overlapping 1001001 -> hit on bit 4 only
    overlap = 1'b0;
    step(1,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0);
    step(1,1,1,0, 4'h9,1,0); step(0,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0);
    step(1,1,1,0, 4'h0,0,0);
    overlap = 1'b1;
    step(1,1,0,0, 4'h0,0,0);

    // 1,1,1,0 -> B on bit 4
    step(1,1,1,0, 4'h0,0,0); step(1,1,1,0, 4'h0,0,0);
    step(1,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'hE,0,1);
    step(1,1,0,0, 4'h0,0,0);

    // both patterns 1111 -> A code, both flags
    pat_a = 4'b1111; pat_b = 4'b1111;
    step(1,1,1,0, 4'h0,0,0); step(1,1,1,0, 4'h0,0,0);
    step(1,1,1,0, 4'h0,0,0); step(1,1,1,0, 4'h9,1,1);
    pat_a = 4'b1001; pat_b = 4'b1110;
    step(1,1,0,0, 4'h0,0,0);

    // 1,0, gap of 3 invalid cycles, 0,1 -> A on the final bit
    step(1,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0);
    step(1,0,1,0, 4'h0,0,0); step(1,0,1,0, 4'h0,0,0); step(0,0,1,0, 4'h0,0,0);
    step(0,1,1,0, 4'h0,0,0); step(1,1,1,0, 4'h9,1,0);
    step(1,1,0,0, 4'h0,0,0);

    // 1,0,0, reset, 1 -> no hit
    step(1,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0);
    rst_pulse();
    step(1,1,1,0, 4'h0,0,0);
    step(1,1,0,0, 4'h0,0,0);

    // five overlapping A hits -> counter saturates at 3
    step(1,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0); step(0,1,1,0, 4'h0,0,0);
    for (int k = 0; k < 5; k++) begin
      step(1,1,1,0, 4'h9,1,0);
      step(0,1,1,0, 4'h0,0,0);
      step(0,1,1,0, 4'h0,0,0);
    end
    // clr together with a hit -> counter cleared
    step(1,1,1,1, 4'h9,1,0);
    step(0,1,1,0, 4'h0,0,0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout step=%0d", stepno);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mealy_seq_det_param.md
MEALY_SEQ_DET_PARAM -- requirements
Module: mealy_seq_det_param

Interface
REQ-001 The block SHALL have a parameter PAT_LEN, default 4, giving the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have a parameter CODE_W, default 4, giving the output code width.
REQ-003 The block SHALL have a parameter CNT_W, default 8, giving the hit-counter width.
REQ-004 The block SHALL have the following ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  1  serial data bit.
- in_vld  input  1  qualifies in; a bit is consumed only when in_vld=1.
- det_en  input  1  detector enable.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clr  input  1  synchronous clear of the hit counters.
- pat_a  input  PAT_LEN  pattern A; MSB is the first bit received.
- pat_b  input  PAT_LEN  pattern B; same bit order as pat_a.
- code_a  input  CODE_W  code driven on out when A matches.
- code_b  input  CODE_W  code driven on out when B matches.
- out  output  CODE_W  Mealy match code.
- hit_a  output  1  pattern A matched this cycle.
- hit_b  output  1  pattern B matched this cycle.
- cnt_a  output  CNT_W  pattern A hit count.
- cnt_b  output  CNT_W  pattern B hit count.

Function
REQ-005 The block SHALL hold a history register of the last PAT_LEN-1 consumed bits and a fill count that saturates at PAT_LEN-1.
REQ-006 Candidate word SHALL be {history, in}.
REQ-007 match_a SHALL be in_vld & det_en & (fill==PAT_LEN-1) & (candidate==pat_a); match_b SHALL be the same test against pat_b.
REQ-008 Outputs SHALL be Mealy, combinational in the same cycle as the completing bit:
- hit_a = match_a; hit_b = match_b.
- out = code_a if match_a; else code_b if match_b; else 0.
- Pattern A SHALL have priority on out; both hit flags SHALL assert when both patterns match.
REQ-009 On a clock edge with in_vld=1 and det_en=1:
- The history register SHALL shift in the in bit.
- With overlap=1, fill SHALL increment, saturating.
- With overlap=0, fill SHALL clear to 0 if match_a or match_b; otherwise it SHALL increment, saturating.
REQ-010 With in_vld=0, history and fill SHALL hold, and out, hit_a and hit_b SHALL be 0.
REQ-011 With det_en=0, fill SHALL clear to 0 on each edge, history SHALL hold, and out, hit_a and hit_b SHALL be 0.
REQ-012 pat_a, pat_b, code_a and code_b SHALL be compared and driven live; no latching is performed.
REQ-013 A combinational path from in/in_vld to out SHALL exist; the block SHALL add no pipeline latency.

Reset
REQ-014 rst_n=0 SHALL asynchronously clear history, fill, cnt_a and cnt_b to 0.
REQ-015 While rst_n=0, out, hit_a and hit_b SHALL be 0.
REQ-016 A reset in mid-sequence SHALL discard any partial match; detection SHALL restart from fill=0.

Configuration
REQ-017 Macro MEALY_SEQ_DET_CNT_EN SHALL compile the hit counters in or out.
REQ-018 With MEALY_SEQ_DET_CNT_EN defined:
- cnt_a SHALL increment on each edge where hit_a=1; cnt_b SHALL increment on each edge where hit_b=1.
- Each counter SHALL saturate at all-ones.
- clr=1 SHALL clear both counters on the next edge; clr SHALL win over a simultaneous hit.
REQ-019 Without MEALY_SEQ_DET_CNT_EN, no counter flops SHALL be present, the ports SHALL remain, cnt_a and cnt_b SHALL be constant 0, and clr SHALL be ignored.

Verification
All scenarios use PAT_LEN=4, pat_a=1001, pat_b=1110, code_a=1001, code_b=1110, det_en=1, in_vld=1 unless stated.
REQ-020 Stream 1,0,0,1 -> out=1001 and hit_a=1 during the 4th bit cycle only; cnt_a=1 afterwards.
REQ-021 Stream 1,0,0,1,0,0,1 -> with overlap=1, hits on bits 4 and 7; with overlap=0, a hit on bit 4 only.
REQ-022 Stream 1,1,1,0 -> out=1110 and hit_b=1 on bit 4; with pat_a=pat_b=1111 and stream 1,1,1,1 -> out=1001, hit_a=hit_b=1.
REQ-023 Stream 1,0,(in_vld=0 for 3 cycles),0,1 -> out=1001 on the final bit; out=0 during the gap. Stream 1,0,0, then rst_n pulse, then 1 -> no hit.
REQ-024 With CNT_W=2 and the macro defined, 5 A-hits -> cnt_a=3. clr asserted in the same cycle as a hit -> cnt_a=0. Without the macro -> cnt_a=cnt_b=0 throughout.
